alineador_palabra: RTL and testbench

Receive-side word-alignment controller for the 10-bit serial link. It watches the raw serial bit stream, finds the K28.5 comma and anchors the 10-bit word boundary to it. It declares lock after a configurable number of aligned commas, then emits one parallel word per 10 enabled clocks with a valid strobe. It replaces the free-running boundary counter of the plain serial-to-parallel converter, and drops lock on repeated misaligned commas.

---
 rtl/alineador_palabra.sv | 158 +++++++++++++++
 tb/tb_alineador_palabra.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alineador_palabra.sv
// alineador_palabra: K28.5 comma word aligner and serial-to-parallel converter for the 10-bit link.
// Optional lock-loss statistics are enabled with `define ALINEADOR_ESTADISTICAS_EN (adds port perdidas).
module alineador_palabra #(
    parameter int                      cantidadBits = 10,
    parameter logic [cantidadBits-1:0] COMMA_P      = 10'b0011111010,
    parameter logic [cantidadBits-1:0] COMMA_N      = 10'b1100000101,
    parameter int                      COMMAS_SYNC  = 3,
    parameter int                      ERRORES_MAX  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic                    entrada,
    output logic [cantidadBits-1:0] palabra,
    output logic                    valida,
    output logic                    sincronizado,
`ifdef ALINEADOR_ESTADISTICAS_EN
    output logic [1:0]              estado,
    output logic [7:0]              perdidas
`else
    output logic [1:0]              estado
`endif
);

    typedef enum logic [1:0] {
        BUSCANDO     = 2'b00,
        VERIFICANDO  = 2'b01,
        SINCRONIZADO = 2'b10
    } estado_t;

    localparam logic [3:0] ULTIMO_BIT  = 4'(cantidadBits - 1);
    localparam logic [2:0] UMBRAL_SYNC = 3'(COMMAS_SYNC);
    localparam logic [2:0] UMBRAL_ERR  = 3'(ERRORES_MAX);

    function automatic logic es_comma(input logic [cantidadBits-1:0] w);
        return (w == COMMA_P) || (w == COMMA_N);
    endfunction

    estado_t                 estado_r;
    logic [cantidadBits-1:0] sr_r;
    logic [3:0]              contador_r;
    logic [2:0]              cuenta_r;
    logic [2:0]              errores_r;

    logic [cantidadBits-1:0] sr_next_s;
    logic                    coincidencia_s;
    logic                    frontera_s;

    assign sr_next_s      = {sr_r[cantidadBits-2:0], entrada};
    assign coincidencia_s = es_comma(sr_next_s);
    assign frontera_s     = (contador_r == ULTIMO_BIT);
    assign estado         = estado_r;

    // Alignment FSM, boundary counter and registered word/strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_r     <= BUSCANDO;
            sr_r         <= '0;
            contador_r   <= 4'd0;
            cuenta_r     <= 3'd0;
            errores_r    <= 3'd0;
            palabra      <= '0;
            valida       <= 1'b0;
            sincronizado <= 1'b0;
        end else if (!enb) begin
            valida <= 1'b0;
        end else begin
            sr_r       <= sr_next_s;
            valida     <= 1'b0;
            contador_r <= frontera_s ? 4'd0 : contador_r + 4'd1;
            case (estado_r)
                BUSCANDO: begin
                    // Any comma seen while searching defines the boundary.
                    if (coincidencia_s) begin
                        contador_r <= 4'd0;
                        cuenta_r   <= 3'd1;
                        if (UMBRAL_SYNC == 3'd1) begin
                            estado_r     <= SINCRONIZADO;
                            sincronizado <= 1'b1;
                            palabra      <= sr_next_s;
                            valida       <= 1'b1;
                        end else begin
                            estado_r <= VERIFICANDO;
                        end
                    end else begin
                        estado_r <= BUSCANDO;
                    end
                end
                VERIFICANDO: begin
                    if (coincidencia_s && frontera_s) begin
                        cuenta_r <= cuenta_r + 3'd1;
                        if (cuenta_r + 3'd1 == UMBRAL_SYNC) begin
                            estado_r     <= SINCRONIZADO;
                            sincronizado <= 1'b1;
                            palabra      <= sr_next_s;
                            valida       <= 1'b1;
                        end else begin
                            estado_r <= VERIFICANDO;
                        end
                    end else if (coincidencia_s) begin
                        contador_r <= 4'd0;
                        cuenta_r   <= 3'd1;
                    end else begin
                        cuenta_r <= cuenta_r;
                    end
                end
                SINCRONIZADO: begin
                    if (frontera_s) begin
                        palabra <= sr_next_s;
                        valida  <= 1'b1;
                    end else begin
                        palabra <= palabra;
                    end
                    if (coincidencia_s && frontera_s) begin
                        errores_r <= 3'd0;
                    end else if (coincidencia_s) begin
                        // Misaligned commas never move the boundary once locked.
                        if (errores_r + 3'd1 == UMBRAL_ERR) begin
                            estado_r     <= BUSCANDO;
                            sincronizado <= 1'b0;
                            errores_r    <= 3'd0;
                            cuenta_r     <= 3'd0;
                        end else begin
                            errores_r <= errores_r + 3'd1;
                        end
                    end else begin
                        errores_r <= errores_r;
                    end
                end
                default: begin
                    estado_r     <= BUSCANDO;
                    sincronizado <= 1'b0;
                    cuenta_r     <= 3'd0;
                    errores_r    <= 3'd0;
                end
            endcase
        end
    end

`ifdef ALINEADOR_ESTADISTICAS_EN
    logic perdida_s;

    assign perdida_s = enb && (estado_r == SINCRONIZADO) && coincidencia_s && !frontera_s &&
                       (errores_r + 3'd1 == UMBRAL_ERR);

    // Saturating count of lock losses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perdidas <= 8'd0;
        end else if (perdida_s && (perdidas != 8'hFF)) begin
            perdidas <= perdidas + 8'd1;
        end else begin
            perdidas <= perdidas;
        end
    end
`endif

endmodule

// File: tb/tb_alineador_palabra.sv
// Self-checking bench for alineador_palabra: bit-index reference model plus directed and random streams.
module tb_alineador_palabra;

    localparam int         CS = 3;
    localparam int         EM = 4;
    localparam logic [9:0] KP = 10'h0FA;
    localparam logic [9:0] KN = 10'h305;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       entrada;
    logic [9:0] palabra;
    logic       valida;
    logic       sincronizado;
    logic [1:0] estado;
`ifdef ALINEADOR_ESTADISTICAS_EN
    logic [7:0] perdidas;
`endif

    alineador_palabra #(
        .cantidadBits(10),
        .COMMA_P(10'b0011111010),
        .COMMA_N(10'b1100000101),
        .COMMAS_SYNC(CS),
        .ERRORES_MAX(EM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .entrada(entrada),
        .palabra(palabra),
        .valida(valida),
        .sincronizado(sincronizado),
`ifdef ALINEADOR_ESTADISTICAS_EN
        .estado(estado),
        .perdidas(perdidas)
`else
        .estado(estado)
`endif
    );

    always #5 clk = ~clk;

    int vectores = 0;
    int fallos   = 0;

    // Reference model: boundaries are bit indices a multiple of 10 after the last anchor.
    int         m_n, m_anchor, m_mode, m_cnt, m_err, m_perd;
    logic [9:0] m_w;
    logic [9:0] e_pal;
    logic       e_val;

    int         cic, ult_cic, sep, nval;
    logic [9:0] pal_ult, pal_prev, pal_primera;

    function void modelo_reset();
        m_n = 0; m_anchor = -1; m_w = 10'd0;
        m_mode = 0; m_cnt = 0; m_err = 0; m_perd = 0;
        e_pal = 10'd0; e_val = 1'b0;
    endfunction

    function void monitor_reset();
        cic = 0; ult_cic = 0; sep = 0; nval = 0;
        pal_ult = 10'd0; pal_prev = 10'd0; pal_primera = 10'd0;
    endfunction

    function void modelo_paso(input logic e, input logic b);
        logic comma, front;
        e_val = 1'b0;
        if (!e) return;
        m_w   = {m_w[8:0], b};
        comma = (m_w == KP) || (m_w == KN);
        front = ((m_n - m_anchor) % 10) == 0;
        if (m_mode == 0) begin
            if (comma) begin
                m_anchor = m_n;
                m_cnt    = 1;
                if (m_cnt == CS) begin m_mode = 2; e_pal = m_w; e_val = 1'b1; end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (comma && front) begin
                m_cnt++;
                if (m_cnt == CS) begin m_mode = 2; e_pal = m_w; e_val = 1'b1; end
            end else if (comma) begin
                m_anchor = m_n;
                m_cnt    = 1;
            end
        end else begin
            if (front) begin e_pal = m_w; e_val = 1'b1; end
            if (comma && front) m_err = 0;
            else if (comma) begin
                m_err++;
                if (m_err == EM) begin
                    m_mode = 0; m_err = 0; m_cnt = 0;
                    if (m_perd < 255) m_perd++;
                end
            end
        end
        m_n++;
    endfunction

    task automatic comparar();
        logic bad;
        cic++;
        vectores++;
        if (valida === 1'b1) begin
            if (nval == 0) pal_primera = palabra;
            sep      = cic - ult_cic;
            ult_cic  = cic;
            pal_prev = pal_ult;
            pal_ult  = palabra;
            nval++;
        end
        bad = (palabra !== e_pal) || (valida !== e_val) ||
              (sincronizado !== (m_mode == 2)) || (estado !== 2'(m_mode));
`ifdef ALINEADOR_ESTADISTICAS_EN
        bad = bad || (perdidas !== 8'(m_perd));
`endif
        if (bad) begin
            fallos++;
            $display("FAIL ciclo %0d t=%0t: palabra=%h/%h valida=%b/%b sincronizado=%b/%b estado=%0d/%0d (dut/modelo)",
                     cic, $time, palabra, e_pal, valida, e_val, sincronizado, (m_mode == 2), estado, m_mode);
        end
    endtask

    task automatic chequear(input string nombre, input int act, input int esp);
        vectores++;
        if (act != esp) begin
            fallos++;
            $display("FAIL %s: got %0h expected %0h", nombre, act, esp);
        end
    endtask

    task automatic ciclo(input logic e, input logic b);
        @(negedge clk);
        comparar();
        enb     = e;
        entrada = b;
        modelo_paso(e, b);
    endtask

    task automatic enviar(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) ciclo(1'b1, w[i]);
    endtask

    task automatic enviar_lento(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            ciclo(1'b1, w[i]);
            ciclo(1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic reiniciar();
        @(negedge clk);
        comparar();
        rst = 1'b0; enb = 1'b0; entrada = 1'b0;
        modelo_reset();
        @(negedge clk);
        comparar();
        monitor_reset();
        rst = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, r;
        logic [9:0] w;
        rst = 1'b0; enb = 1'b0; entrada = 1'b0;
        modelo_reset();
        monitor_reset();
        repeat (2) @(negedge clk);
        chequear("reset_palabra", palabra, 0);
        chequear("reset_valida", valida, 0);
        chequear("reset_sincronizado", sincronizado, 0);
        chequear("reset_estado", estado, 0);
        rst = 1'b1;

        // Lock on COMMA_P with a 3-bit offset.
        ciclo(1'b1, 1'b1); ciclo(1'b1, 1'b0); ciclo(1'b1, 1'b1);
        repeat (3) enviar(KP);
        ciclo(1'b0, 1'b0);
        chequear("lock_sincronizado", sincronizado, 1);
        chequear("lock_estado", estado, 2);
        chequear("lock_primera_palabra", pal_primera, 'h0FA);
        chequear("lock_nval", nval, 1);
        repeat (2) enviar(KP);
        ciclo(1'b0, 1'b0);
        chequear("lock_separacion", sep, 10);

        // Data word followed by the opposite-disparity comma.
        enviar(10'h2AA);
        enviar(KN);
        ciclo(1'b0, 1'b0);
        chequear("dato_palabra", pal_prev, 'h2AA);
        chequear("commaN_palabra", pal_ult, 'h305);
        chequear("commaN_sincronizado", sincronizado, 1);

        // Four progressively slipped commas drop lock.
        repeat (4) begin
            ciclo(1'b1, 1'b0);
            enviar(KP);
        end
        ciclo(1'b0, 1'b0);
        chequear("perdida_sincronizado", sincronizado, 0);
        chequear("perdida_estado", estado, 0);
        chequear("perdida_valida", valida, 0);
`ifdef ALINEADOR_ESTADISTICAS_EN
        chequear("perdidas", perdidas, 1);
`endif
        n0 = nval;
        repeat (20) ciclo(1'b1, 1'b0);
        ciclo(1'b0, 1'b0);
        chequear("sin_valida_tras_perdida", nval - n0, 0);

        // Re-anchor while verifying.
        reiniciar();
        enviar(KP); enviar(KP);
        ciclo(1'b0, 1'b0);
        chequear("verif_estado", estado, 1);
        repeat (5) ciclo(1'b1, 1'b0);
        enviar(KP);
        enviar(KP);
        ciclo(1'b0, 1'b0);
        chequear("reancla_estado", estado, 1);
        chequear("reancla_sincronizado", sincronizado, 0);
        enviar(KP);
        ciclo(1'b0, 1'b0);
        chequear("reancla_lock", sincronizado, 1);

        // Half-rate enable while locked.
        enviar_lento(KP);
        enviar_lento(10'h155);
        enviar_lento(KP);
        ciclo(1'b0, 1'b0);
        chequear("lento_separacion", sep, 20);
        chequear("lento_dato", pal_prev, 'h155);
        chequear("lento_comma", pal_ult, 'h0FA);

        // Asynchronous reset mid-word while locked.
        enviar(KP);
        ciclo(1'b1, 1'b1); ciclo(1'b1, 1'b0); ciclo(1'b1, 1'b1); ciclo(1'b1, 1'b0);
        @(posedge clk);
        #1;
        chequear("pre_reset_sincronizado", sincronizado, 1);
        #1;
        rst = 1'b0;
        #1;
        chequear("async_palabra", palabra, 0);
        chequear("async_valida", valida, 0);
        chequear("async_sincronizado", sincronizado, 0);
        chequear("async_estado", estado, 0);
        modelo_reset();
        monitor_reset();
        enb = 1'b0;
        @(negedge clk);
        comparar();
        rst = 1'b1;
        repeat (3) enviar(KN);
        ciclo(1'b0, 1'b0);
        chequear("readq_sincronizado", sincronizado, 1);
        chequear("readq_palabra", pal_primera, 'h305);

        // Random streams of commas, data, slips and idle cycles.
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 199) == 0) reiniciar();
            r = $urandom_range(0, 9);
            if (r <= 3)      w = KP;
            else if (r <= 5) w = KN;
            else             w = 10'($urandom);
            if (r == 9) begin
                repeat ($urandom_range(1, 9)) ciclo(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                for (int i = 9; i >= 0; i--) begin
                    if ($urandom_range(0, 4) == 0) ciclo(1'b0, 1'($urandom_range(0, 1)));
                    ciclo(1'b1, w[i]);
                end
            end
        end
        ciclo(1'b0, 1'b0);
        ciclo(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule
